// File: rtl/interrupt_resolver_pkg.sv
// Shared types and constants for the interrupt request/priority stage.
package pic_pkg;

  typedef logic [2:0] level_t;

  localparam int     VEC_BASE_W = 5;
  localparam level_t LP_RESET   = 3'd7;

  // {eoi_rot, eoi_sl} decode
  typedef enum logic [1:0] {
    EOI_NS     = 2'b00,
    EOI_SP     = 2'b01,
    EOI_ROT_NS = 2'b10,
    EOI_ROT_SP = 2'b11
  } eoi_mode_t;

  function automatic logic [7:0] lvl_bit(input level_t lvl);
    lvl_bit = 8'd1 << lvl;
  endfunction

endpackage

// File: rtl/interrupt_resolver_if.sv
// Handshake between the request/priority stage and the controller's control logic.
interface interrupt_resolver_if;
  import pic_pkg::*;

  logic [VEC_BASE_W-1:0] vec_base;
  logic                  ack1;
  logic                  ack2;
  logic                  eoi;
  logic                  eoi_sl;
  level_t                eoi_lvl;
  logic                  eoi_rot;
  logic [7:0]            irr;
  logic [7:0]            isr;
  logic                  int_req;
  logic [7:0]            vector;

  modport master (
    output vec_base, ack1, ack2, eoi, eoi_sl, eoi_lvl, eoi_rot,
    input  irr, isr, int_req, vector
  );

  modport slave (
    input  vec_base, ack1, ack2, eoi, eoi_sl, eoi_lvl, eoi_rot,
    output irr, isr, int_req, vector
  );
endinterface

// File: rtl/interrupt_resolver_prio_pick.sv
// Rotating priority encoder: level lp+1 ranks highest, lp ranks lowest.
module prio_pick
  import pic_pkg::*;
(
  input  logic [7:0] req,
  input  level_t     lp,
  output logic       valid,
  output level_t     level
);

  level_t idx_s;

  // Walk from lowest to highest rank so the highest-ranked set bit wins last
  always_comb begin
    valid = 1'b0;
    level = 3'd0;
    idx_s = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      idx_s = level_t'(lp + 3'd1 + 3'(k));
      valid = valid | req[idx_s];
      level = req[idx_s] ? idx_s : level;
    end
  end

endmodule

// File: rtl/interrupt_resolver.sv
// IRR capture, masking, fully nested priority resolution, ISR/EOI handling.
// Optional automatic EOI on ack2: define INTERRUPT_RESOLVER_AEOI_EN.
module interrupt_resolver
  import pic_pkg::*;
#(
  parameter int     NUM_IR       = 8,
  parameter level_t RESET_LOWEST = LP_RESET
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IR-1:0] ir,
  input  logic              ltim,
  input  logic [NUM_IR-1:0] imr,
  interrupt_resolver_if.slave bus
);

  logic [NUM_IR-1:0] ir_prev_r;
  logic [NUM_IR-1:0] irr_r;
  logic [NUM_IR-1:0] isr_r;
  logic              int_req_r;
  logic [7:0]        vector_r;
  level_t            lp_r;
  level_t            level_r;

  logic [NUM_IR-1:0] pend_s;
  logic              cand_valid_s;
  level_t            cand_lvl_s;
  logic              isr_valid_s;
  level_t            isr_lvl_s;
  level_t            rank_cand_s;
  level_t            rank_isr_s;
  logic              int_req_next_s;
  logic [NUM_IR-1:0] ack1_bit_s;
  logic [NUM_IR-1:0] irr_next_s;
  eoi_mode_t         eoi_mode_s;
  logic              eoi_hit_s;
  logic              eoi_rot_s;
  level_t            eoi_tgt_s;
  logic [NUM_IR-1:0] eoi_clr_s;
  logic              aeoi_fire_s;
  logic [NUM_IR-1:0] aeoi_clr_s;
  logic [NUM_IR-1:0] isr_next_s;
  level_t            lp_next_s;

  assign pend_s = irr_r & ~imr;

  prio_pick u_cand (
    .req   (pend_s),
    .lp    (lp_r),
    .valid (cand_valid_s),
    .level (cand_lvl_s)
  );

  prio_pick u_isr_hi (
    .req   (isr_r),
    .lp    (lp_r),
    .valid (isr_valid_s),
    .level (isr_lvl_s)
  );

  // Rank 0 is the highest priority; request only if strictly above the serviced level
  assign rank_cand_s    = level_t'(cand_lvl_s - lp_r - 3'd1);
  assign rank_isr_s     = level_t'(isr_lvl_s - lp_r - 3'd1);
  assign int_req_next_s = cand_valid_s & (~isr_valid_s | (rank_cand_s < rank_isr_s));

  assign ack1_bit_s = (bus.ack1 && cand_valid_s) ? lvl_bit(cand_lvl_s) : 8'd0;

  // Level mode follows the line except for the bit being acknowledged; edge mode lets a new set beat the clear
  always_comb begin
    irr_next_s = irr_r;
    if (ltim) begin
      irr_next_s = ir & ~ack1_bit_s;
    end else begin
      irr_next_s = (irr_r & ~ack1_bit_s) | (ir & ~ir_prev_r);
    end
  end

  assign eoi_mode_s = eoi_mode_t'({bus.eoi_rot, bus.eoi_sl});

  // EOI target selection; a target with no isr bit set is a no-op
  always_comb begin
    eoi_tgt_s = isr_lvl_s;
    eoi_hit_s = 1'b0;
    eoi_rot_s = 1'b0;
    if (bus.eoi) begin
      case (eoi_mode_s)
        EOI_NS: begin
          eoi_tgt_s = isr_lvl_s;
          eoi_hit_s = isr_valid_s;
        end
        EOI_SP: begin
          eoi_tgt_s = bus.eoi_lvl;
          eoi_hit_s = isr_r[bus.eoi_lvl];
        end
        EOI_ROT_NS: begin
          eoi_tgt_s = isr_lvl_s;
          eoi_hit_s = isr_valid_s;
          eoi_rot_s = 1'b1;
        end
        EOI_ROT_SP: begin
          eoi_tgt_s = bus.eoi_lvl;
          eoi_hit_s = isr_r[bus.eoi_lvl];
          eoi_rot_s = 1'b1;
        end
        default: begin
          eoi_tgt_s = isr_lvl_s;
          eoi_hit_s = 1'b0;
          eoi_rot_s = 1'b0;
        end
      endcase
    end else begin
      eoi_hit_s = 1'b0;
    end
  end

  assign eoi_clr_s = eoi_hit_s ? lvl_bit(eoi_tgt_s) : 8'd0;

`ifdef INTERRUPT_RESOLVER_AEOI_EN
  logic lvl_vld_r;

  assign aeoi_fire_s = bus.ack2 & ~bus.ack1 & lvl_vld_r;

  // Remembers whether the latched level came from a real (non-spurious) ack1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lvl_vld_r <= 1'b0;
    end else if (bus.ack1) begin
      lvl_vld_r <= cand_valid_s;
    end else if (aeoi_fire_s) begin
      lvl_vld_r <= 1'b0;
    end else begin
      lvl_vld_r <= lvl_vld_r;
    end
  end
`else
  assign aeoi_fire_s = 1'b0;
`endif

  assign aeoi_clr_s = aeoi_fire_s ? lvl_bit(level_r) : 8'd0;
  assign isr_next_s = (isr_r & ~eoi_clr_s & ~aeoi_clr_s) | ack1_bit_s;

  // Rotation follows the level actually retired
  always_comb begin
    lp_next_s = lp_r;
    if (eoi_hit_s && eoi_rot_s) begin
      lp_next_s = eoi_tgt_s;
    end else if (aeoi_fire_s && bus.eoi_rot) begin
      lp_next_s = level_r;
    end else begin
      lp_next_s = lp_r;
    end
  end

  // State registers; ack2 coinciding with ack1 is ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_prev_r <= 8'd0;
      irr_r     <= 8'd0;
      isr_r     <= 8'd0;
      int_req_r <= 1'b0;
      vector_r  <= 8'd0;
      lp_r      <= RESET_LOWEST;
      level_r   <= 3'd0;
    end else begin
      ir_prev_r <= ir;
      irr_r     <= irr_next_s;
      isr_r     <= isr_next_s;
      int_req_r <= int_req_next_s;
      lp_r      <= lp_next_s;
      if (bus.ack1) begin
        level_r <= cand_valid_s ? cand_lvl_s : 3'd7;
      end else begin
        level_r <= level_r;
      end
      if (bus.ack2 && !bus.ack1) begin
        vector_r <= {bus.vec_base, level_r};
      end else begin
        vector_r <= vector_r;
      end
    end
  end

  assign bus.irr     = irr_r;
  assign bus.isr     = isr_r;
  assign bus.int_req = int_req_r;
  assign bus.vector  = vector_r;

endmodule

// File: doc/interrupt_resolver.md
# interrupt_resolver

- Request/priority stage of the interrupt controller, directly upstream of the control logic.
- Captures raw interrupt request lines into the IRR, applies the mask, and resolves the highest-priority pending request against the in-service register (ISR).
- Raises the interrupt request toward the control logic and updates ISR/IRR on the control logic's acknowledge strobes.
- Produces the 8-bit vector and handles EOI commands, with fixed or rotating priority.

## Interface
Parameters:
- NUM_IR, 8, number of request lines; must be 8.
- RESET_LOWEST, 3'd7, reset value of the lowest-priority level; 7 gives fixed order IR0 highest.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- ir  in  8  raw request lines, synchronous to clk.
- ltim  in  1  1 = level-triggered, 0 = edge-triggered.
- imr  in  8  mask; 1 masks the line.
- vec_base  in  5  vector bits T7..T3.
- ack1  in  1  one-cycle strobe, first INTA.
- ack2  in  1  one-cycle strobe, second INTA.
- eoi  in  1  one-cycle EOI command strobe.
- eoi_sl  in  1  1 = specific EOI, 0 = non-specific EOI.
- eoi_lvl  in  3  level for a specific EOI.
- eoi_rot  in  1  rotate on this EOI.
- irr  out  8  request register, feeds the control logic.
- isr  out  8  in-service register.
- int_req  out  1  registered interrupt request.
- vector  out  8  {vec_base, level}; valid from the cycle after ack2.

## Operation
Reset values:
- irr, isr, int_req, vector, and the ir history register are all 0.
- The lowest-priority register lp = RESET_LOWEST.

Request capture:
- Edge mode: irr[i] sets on a 0→1 transition of ir[i] against its registered previous value. It clears only on ack1 selecting i.
- Level mode: irr[i] is loaded from ir[i] every cycle. The bit selected by ack1 is forced to 0 in that cycle.
- If a set and an ack1 clear hit the same bit in the same cycle, the set wins.

Priority:
- Rank order starts at lp+1 (highest) and wraps around to lp (lowest).
- Candidate: the highest-ranked bit of irr & ~imr.
- int_req is 1 when a candidate exists and ranks strictly above the highest-ranked isr bit (fully nested), or when isr is 0.

ack1:
- With a candidate: set isr[c], clear irr[c], and latch c as the level.
- With no candidate (spurious): latch level 7 and leave isr and irr unchanged.

ack2:
- vector ← {vec_base, latched level}.

EOI:
- Non-specific: clears the highest-ranked isr bit.
- Specific: clears isr[eoi_lvl].
- With eoi_rot set, lp ← the cleared level.
- An EOI that clears no bit is a no-op, and lp is unchanged.

Simultaneous events:
- EOI and ack1 in the same cycle: the EOI acts on the pre-ack isr; the ack1 set is then OR-ed in.
- ack1 and ack2 asserted together: this is a protocol error. ack1 is processed and ack2 is ignored.

imr:
- Changes affect candidate selection the same cycle.
- They never clear irr or isr.

## Timing
- ir rising (edge mode) → irr bit set at the next clk edge → int_req set one clk later. Total 2 cycles.
- ack1 at edge N → isr/irr updated at N; int_req recomputed from the new state and valid at N+1.
- ack2 at edge N → vector valid after N and held until the next ack2 or reset.
- EOI at edge N → isr bit cleared at N; a pending lower request raises int_req at N+1.
- rst asserted mid-sequence (between ack1 and ack2) clears everything immediately. A later stray ack2 outputs {vec_base, 3'd0}.

## Configuration
- Macro: INTERRUPT_RESOLVER_AEOI_EN.
- Defined: ack2 also clears the isr bit set by the preceding ack1 (automatic EOI). If eoi_rot is high during ack2, lp ← that level.
- Undefined: isr bits clear only through the eoi command.
- The macro has no effect on irr, int_req latency, or vector timing.

## Structure
- Package pic_pkg holds:
  - the level type (3 bits);
  - the vector-base width constant;
  - EOI mode encodings;
  - the RESET_LOWEST default.
- Sub-module prio_pick: combinational rotating priority encoder.
  - Inputs: 8-bit request, lp.
  - Outputs: valid, level.
  - Instantiated twice: once for the candidate, once for the highest isr bit.

## Test plan
- Edge mode, imr=0, ir=8'h24 pulse → irr=8'h24 after 1 cycle, int_req=1 after 2. ack1 → isr=8'h04, irr=8'h20. ack2 with vec_base=5'h08 → vector=8'h42.
- Nesting: isr=8'h04, ir5 pending → int_req=0. Raise ir0 → int_req=1. Non-specific EOI → isr bit 0 cleared first.
- Rotation: isr=8'h08, EOI with eoi_rot=1 → lp=3. Pending irr=8'h11 → next ack1 selects level 4.
- Spurious: ack1 while irr & ~imr = 0 → isr unchanged, ack2 → vector={vec_base,3'd7}.
- Level mode: ir2 held high → irr[2] stays set. After ack1, irr[2] reappears the next cycle. Drop ir2 → irr[2]=0.
- AEOI build: ack1/ack2 on level 6 → isr=0 after ack2. Non-AEOI build → isr=8'h40 until eoi.
